rx_frame_checker: RTL and testbench

Payload checker at the Rx AXI-stream output (`data_tdata/tuser/tlast/tvalid`) in the 1.024 MHz domain. It regenerates the known PRBS-9 frame payload locally and compares each received byte against it. It accumulates bit, bit-error, frame and frame-error counts, and raises a lock flag after a run of clean frames. BPSK/QPSK loopback benches and board bring-up use it to measure BER without a host.

---
 rtl/rx_check_pkg.sv | 26 ++
 rtl/rx_frame_checker_if.sv | 9 +
 rtl/prbs9_byte_gen.sv | 21 ++
 rtl/rx_frame_checker.sv | 92 +++++++++
 tb/tb_rx_frame_checker.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/rx_check_pkg.sv
// rx_check_pkg: shared PRBS-9 constants, FSM encoding and counter widths for the Rx frame checker
package rx_check_pkg;
  localparam logic [8:0] PRBS9_SEED = 9'h1FF;
  localparam int PRBS9_TAP_A = 8;
  localparam int PRBS9_TAP_B = 4;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_IN_FRAME = 1'b1;
  localparam int BIT_CNT_W = 32;
  localparam int FRAME_CNT_W = 16;
  localparam int BYTE_CNT_W = 16;
  localparam int STREAK_W = 8;
  typedef struct packed {
    logic [8:0] s;
    logic [7:0] b;
  } prbs9_step_t;
  function automatic prbs9_step_t prbs9_step8(input logic [8:0] s_in);
    prbs9_step_t r;
    r.s = s_in;
    r.b = '0;
    for (int i = 0; i < 8; i++) begin
      r.b = {r.b[6:0], r.s[PRBS9_TAP_A]};
      r.s = {r.s[7:0], r.s[PRBS9_TAP_A] ^ r.s[PRBS9_TAP_B]};
    end
    return r;
  endfunction
endpackage

// File: rtl/rx_frame_checker_if.sv
// rx_frame_checker_if: receive AXI-stream byte bus without backpressure
interface rx_frame_checker_if;
  logic [7:0] tdata;
  logic tvalid;
  logic tuser;
  logic tlast;
  modport master(output tdata, tvalid, tuser, tlast);
  modport slave(input tdata, tvalid, tuser, tlast);
endinterface

// File: rtl/prbs9_byte_gen.sv
// prbs9_byte_gen: byte-wide PRBS-9 reference, exp_byte is the next expected byte (seed byte while load)
module prbs9_byte_gen
  import rx_check_pkg::*;
(
  input  logic       clk_1M024,
  input  logic       rst_n_1M024,
  input  logic       load,
  input  logic       adv,
  output logic [7:0] exp_byte
);
  logic [8:0] s;
  prbs9_step_t nx;
  // eight LFSR steps from either the seed or the running state
  always_comb nx = prbs9_step8(load ? PRBS9_SEED : s);
  assign exp_byte = nx.b;
  // keep the LFSR aligned with the compared byte stream
  always_ff @(posedge clk_1M024)
    if (!rst_n_1M024) s <= PRBS9_SEED;
    else if (adv) s <= nx.s;
    else if (load) s <= PRBS9_SEED;
endmodule

// File: rtl/rx_frame_checker.sv
// rx_frame_checker: PRBS-9 payload checker with BER, frame counters and lock detection
module rx_frame_checker
  import rx_check_pkg::*;
#(
  parameter int FRAME_LEN = 64,
  parameter int LOCK_FRAMES = 4
) (
  input  logic                   clk_1M024,
  input  logic                   rst_n_1M024,
  rx_frame_checker_if.slave      data,
  input  logic                   clr,
  output logic [BIT_CNT_W-1:0]   bit_cnt,
  output logic [BIT_CNT_W-1:0]   bit_err_cnt,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic [FRAME_CNT_W-1:0] frame_err_cnt,
  output logic                   locked,
  output logic                   err_pulse
);
  logic [0:0] state;
  logic [BYTE_CNT_W-1:0] byte_cnt, cnt_n;
  logic [STREAK_W-1:0] streak, streak_a, streak_n;
  logic [7:0] exp_byte, diff;
  logic [1:0] p [4];
  logic [2:0] q [2];
  logic [3:0] errs, errs_c;
  logic bad, bad_n, accept, sof, cmp, abort, close, close_bad, locked_n;
  logic [1:0] n_close, n_err;
  logic [BIT_CNT_W:0] bit_sum, berr_sum;
  logic [FRAME_CNT_W:0] fr_sum, fe_sum;

  prbs9_byte_gen u_gen (
    .clk_1M024(clk_1M024),
    .rst_n_1M024(rst_n_1M024),
    .load(sof),
    .adv(cmp),
    .exp_byte(exp_byte)
  );

  // byte qualification, popcount tree, frame bookkeeping and saturating sums
  always_comb begin
    accept = data.tvalid & ~clr;
    sof = accept & data.tuser;
    cmp = sof | (accept & (state == ST_IN_FRAME));
    abort = sof & (state == ST_IN_FRAME);
    diff = data.tdata ^ exp_byte;
    for (int i = 0; i < 4; i++) p[i] = {1'b0, diff[2*i]} + {1'b0, diff[2*i+1]};
    for (int i = 0; i < 2; i++) q[i] = {1'b0, p[2*i]} + {1'b0, p[2*i+1]};
    errs = {1'b0, q[0]} + {1'b0, q[1]};
    errs_c = cmp ? errs : 4'd0;
    cnt_n = sof ? BYTE_CNT_W'(1) : byte_cnt + {{(BYTE_CNT_W-1){1'b0}}, byte_cnt != '1};
    bad_n = (~sof & bad) | (errs != 4'd0) | (int'(cnt_n) > FRAME_LEN);
    close = cmp & data.tlast;
    close_bad = bad_n | (int'(cnt_n) != FRAME_LEN);
    n_close = {1'b0, abort} + {1'b0, close};
    n_err = {1'b0, abort} + {1'b0, close & close_bad};
    streak_a = abort ? '0 : streak;
    streak_n = !close ? streak_a : close_bad ? '0 : streak_a + {{(STREAK_W-1){1'b0}}, streak_a != '1};
    locked_n = close ? (!close_bad && int'(streak_n) >= LOCK_FRAMES) : abort ? 1'b0 : locked;
    bit_sum = {1'b0, bit_cnt} + {{(BIT_CNT_W-3){1'b0}}, cmp, 3'b000};
    berr_sum = {1'b0, bit_err_cnt} + {{(BIT_CNT_W-3){1'b0}}, errs_c};
    fr_sum = {1'b0, frame_cnt} + {{(FRAME_CNT_W-1){1'b0}}, n_close};
    fe_sum = {1'b0, frame_err_cnt} + {{(FRAME_CNT_W-1){1'b0}}, n_err};
  end

  // state and counters advance only on compared bytes; reset and clr wipe everything
  always_ff @(posedge clk_1M024)
    if (!rst_n_1M024 || clr) begin
      state <= ST_IDLE;
      byte_cnt <= '0;
      bad <= 1'b0;
      streak <= '0;
      bit_cnt <= '0;
      bit_err_cnt <= '0;
      frame_cnt <= '0;
      frame_err_cnt <= '0;
      locked <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= cmp & (errs != 4'd0);
      if (cmp) begin
        state <= close ? ST_IDLE : ST_IN_FRAME;
        byte_cnt <= cnt_n;
        bad <= bad_n;
        streak <= streak_n;
        locked <= locked_n;
        bit_cnt <= bit_sum[BIT_CNT_W] ? '1 : bit_sum[BIT_CNT_W-1:0];
        bit_err_cnt <= berr_sum[BIT_CNT_W] ? '1 : berr_sum[BIT_CNT_W-1:0];
        frame_cnt <= fr_sum[FRAME_CNT_W] ? '1 : fr_sum[FRAME_CNT_W-1:0];
        frame_err_cnt <= fe_sum[FRAME_CNT_W] ? '1 : fe_sum[FRAME_CNT_W-1:0];
      end
    end
endmodule

// File: tb/tb_rx_frame_checker.sv
// tb_rx_frame_checker: table, directed and random checks of rx_frame_checker against a frame-level model
module tb_rx_frame_checker;
  localparam int FL = 64;
  localparam int LF = 4;
  logic clk_1M024 = 1'b0;
  logic rst_n_1M024 = 1'b0;
  logic clr = 1'b0;
  logic [31:0] bit_cnt, bit_err_cnt;
  logic [15:0] frame_cnt, frame_err_cnt;
  logic locked, err_pulse;
  int checks = 0;
  int errors = 0;
  logic [7:0] prbs [512];
  int m_bits, m_berr, m_fr, m_fe, m_streak, m_idx;
  bit m_locked, m_pulse, m_in, m_bad;

  typedef struct {
    logic [7:0] d;
    logic u, l, v, c;
    int bits, berr;
    logic pulse;
    int fr, fe;
  } vec_t;
  vec_t tbl [10];

  rx_frame_checker_if data ();

  rx_frame_checker #(.FRAME_LEN(FL), .LOCK_FRAMES(LF)) dut (
    .clk_1M024(clk_1M024),
    .rst_n_1M024(rst_n_1M024),
    .data(data),
    .clr(clr),
    .bit_cnt(bit_cnt),
    .bit_err_cnt(bit_err_cnt),
    .frame_cnt(frame_cnt),
    .frame_err_cnt(frame_err_cnt),
    .locked(locked),
    .err_pulse(err_pulse)
  );

  always #5 clk_1M024 = ~clk_1M024;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all();
    chk("bit_cnt", bit_cnt, 32'(m_bits));
    chk("bit_err_cnt", bit_err_cnt, 32'(m_berr));
    chk("frame_cnt", {16'd0, frame_cnt}, 32'(m_fr));
    chk("frame_err_cnt", {16'd0, frame_err_cnt}, 32'(m_fe));
    chk("locked", {31'd0, locked}, {31'd0, m_locked});
    chk("err_pulse", {31'd0, err_pulse}, {31'd0, m_pulse});
  endtask

  task automatic m_zero();
    m_bits = 0; m_berr = 0; m_fr = 0; m_fe = 0; m_streak = 0;
    m_locked = 0; m_pulse = 0; m_in = 0; m_bad = 0; m_idx = 0;
  endtask

  task automatic m_close(input bit bad);
    m_fr++;
    if (bad) begin
      m_fe++;
      m_streak = 0;
      m_locked = 0;
    end else begin
      m_streak++;
      if (m_streak >= LF) m_locked = 1;
    end
  endtask

  task automatic m_byte(input logic [7:0] d, input logic u, l, v, c);
    int e;
    if (c) begin
      m_zero();
      return;
    end
    m_pulse = 0;
    if (!v) return;
    if (u) begin
      if (m_in) m_close(1);
      m_in = 1;
      m_idx = 0;
      m_bad = 0;
    end
    if (!m_in) return;
    e = $countones(d ^ prbs[m_idx]);
    m_bits += 8;
    m_berr += e;
    m_pulse = (e != 0);
    m_bad = m_bad | (e != 0);
    m_idx++;
    if (l) begin
      m_close(m_bad || m_idx != FL);
      m_in = 0;
    end
  endtask

  task automatic step(input logic [7:0] d, input logic u, l, v, c);
    data.tdata = d;
    data.tuser = u;
    data.tlast = l;
    data.tvalid = v;
    clr = c;
    @(posedge clk_1M024);
    m_byte(d, u, l, v, c);
    #1;
    chk_all();
  endtask

  task automatic do_reset();
    data.tvalid = 0;
    clr = 0;
    rst_n_1M024 = 0;
    @(posedge clk_1M024);
    m_zero();
    #1;
    chk_all();
    rst_n_1M024 = 1;
  endtask

  task automatic send_frame(input int len, input bit last, input int err_pos, input logic [7:0] mask, input int gap_pct);
    for (int i = 0; i < len; i++) begin
      while ($urandom_range(0, 99) < gap_pct) step(8'($urandom), 1'($urandom), 1'($urandom), 0, 0);
      step(prbs[i] ^ (i == err_pos ? mask : 8'h00), i == 0, last && i == len - 1, 1, 0);
    end
  endtask

  initial begin
    logic [8:0] s;
    s = 9'h1FF;
    for (int i = 0; i < 512; i++)
      for (int b = 0; b < 8; b++) begin
        prbs[i] = {prbs[i][6:0], s[8]};
        s = {s[7:0], s[8] ^ s[4]};
      end
    tbl[0] = '{8'h00, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{8'hAA, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{8'hFF, 1, 1, 1, 0, 8, 0, 0, 1, 1};
    tbl[3] = '{8'hFE, 1, 0, 1, 0, 16, 1, 1, 1, 1};
    tbl[4] = '{8'hFE, 1, 1, 0, 0, 16, 1, 0, 1, 1};
    tbl[5] = '{8'h00, 1, 1, 1, 0, 24, 9, 1, 3, 3};
    tbl[6] = '{8'h0F, 1, 0, 1, 1, 0, 0, 0, 0, 0};
    tbl[7] = '{8'hFF, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    tbl[8] = '{8'hF0, 1, 0, 1, 0, 8, 4, 1, 0, 0};
    tbl[9] = '{8'h7F, 1, 1, 1, 0, 16, 5, 1, 2, 2};
    data.tdata = 0; data.tuser = 0; data.tlast = 0; data.tvalid = 0;
    m_zero();
    do_reset();
    chk("reset_bits", bit_cnt, 0);
    chk("reset_frames", {16'd0, frame_cnt}, 0);
    chk("reset_locked", {31'd0, locked}, 0);
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].d, tbl[i].u, tbl[i].l, tbl[i].v, tbl[i].c);
      chk($sformatf("tbl%0d_bits", i), bit_cnt, 32'(tbl[i].bits));
      chk($sformatf("tbl%0d_berr", i), bit_err_cnt, 32'(tbl[i].berr));
      chk($sformatf("tbl%0d_pulse", i), {31'd0, err_pulse}, {31'd0, tbl[i].pulse});
      chk($sformatf("tbl%0d_fr", i), {16'd0, frame_cnt}, 32'(tbl[i].fr));
      chk($sformatf("tbl%0d_fe", i), {16'd0, frame_err_cnt}, 32'(tbl[i].fe));
    end
    step(0, 0, 0, 0, 1);
    for (int f = 0; f < 3; f++) send_frame(64, 1, -1, 0, 0);
    chk("clean_bits", bit_cnt, 1536);
    chk("clean_berr", bit_err_cnt, 0);
    chk("clean_fr", {16'd0, frame_cnt}, 3);
    chk("clean_fe", {16'd0, frame_err_cnt}, 0);
    chk("clean_unlocked", {31'd0, locked}, 0);
    send_frame(64, 1, -1, 0, 0);
    chk("clean_locked", {31'd0, locked}, 1);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 64; i++) begin
      step(i == 0 ? 8'hFE : prbs[i], i == 0, i == 63, 1, 0);
      if (i < 2) chk($sformatf("inj_pulse%0d", i), {31'd0, err_pulse}, i == 0 ? 32'd1 : 32'd0);
    end
    chk("inj_berr", bit_err_cnt, 1);
    chk("inj_fe", {16'd0, frame_err_cnt}, 1);
    chk("inj_locked", {31'd0, locked}, 0);
    step(0, 0, 0, 0, 1);
    send_frame(63, 1, -1, 0, 0);
    chk("short_fe", {16'd0, frame_err_cnt}, 1);
    chk("short_berr", bit_err_cnt, 0);
    chk("short_bits", bit_cnt, 504);
    step(0, 0, 0, 0, 1);
    send_frame(10, 0, -1, 0, 0);
    send_frame(64, 1, -1, 0, 0);
    chk("abort_fr", {16'd0, frame_cnt}, 2);
    chk("abort_fe", {16'd0, frame_err_cnt}, 1);
    chk("abort_berr", bit_err_cnt, 0);
    chk("abort_bits", bit_cnt, 592);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(prbs[i], 0, i == 4, 1, 0);
    chk("stray_bits", bit_cnt, 0);
    chk("stray_fr", {16'd0, frame_cnt}, 0);
    send_frame(5, 0, 2, 8'h81, 0);
    step(8'hFF, 1, 0, 1, 1);
    chk("clr_bits", bit_cnt, 0);
    chk("clr_berr", bit_err_cnt, 0);
    chk("clr_pulse", {31'd0, err_pulse}, 0);
    send_frame(20, 0, -1, 0, 0);
    do_reset();
    send_frame(64, 1, -1, 0, 0);
    chk("rst_fr", {16'd0, frame_cnt}, 1);
    chk("rst_fe", {16'd0, frame_err_cnt}, 0);
    for (int n = 0; n < 80; n++) begin
      int len, ep;
      len = ($urandom_range(0, 9) < 6) ? 64 : $urandom_range(1, 80);
      ep = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      if ($urandom_range(0, 19) == 0) step(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1);
      if ($urandom_range(0, 9) == 0) step(8'($urandom), 0, 1'($urandom), 1, 0);
      send_frame(len, $urandom_range(0, 7) != 0, ep, 8'($urandom_range(1, 255)), $urandom_range(0, 1) * 15);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
